sha3_256_padder: RTL and testbench

Message-side front end for the SHA3-256 sponge. Accepts a byte-oriented message as a stream of 64-bit little-endian words. Packs the words into 1088-bit rate blocks and applies the SHA3 domain suffix and pad10*1 (0x06 … 0x80). Presents each block to the sponge absorber over a valid/ready handshake, with first/last markers so the absorber knows when to clear its state and when to start the squeeze.

---
 rtl/sha3_256_padder_if.sv | 28 ++
 rtl/sha3_256_padder.sv | 124 ++++++++++++
 tb/tb_sha3_256_padder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_256_padder_if.sv
// Handshake bundle between a message source and the SHA3-256 padder, and
// between the padder and the sponge absorber.
//   in_*  : 64-bit little-endian message words, in_last/in_nbytes mark the tail
//   blk_* : 1088-bit rate blocks with first/last markers for the absorber
// modport slave  : the padder side
// modport master : the message source / absorber side
interface sha3_256_padder_if;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_nbytes;
    logic          blk_valid;
    logic          blk_ready;
    logic [1087:0] blk_data;
    logic          blk_first;
    logic          blk_last;

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last
    );

    modport master (
        output in_valid, in_data, in_last, in_nbytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last
    );
endinterface

// File: rtl/sha3_256_padder.sv
// SHA3-256 message padder.
// Packs 64-bit message words into 1088-bit rate blocks, applies the SHA3
// domain suffix 0x06 and the closing 0x80 of pad10*1, and hands each block to
// the absorber over a valid/ready handshake with first/last markers.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sha3_256_padder_if.slave (word input side and block output side)
//
// state   | meaning
// FILL    | accepting words into lane wcnt of the block buffer
// EMIT    | presenting the block buffer, waiting for blk_ready
module sha3_256_padder #(
    parameter int RATE_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    sha3_256_padder_if.slave   bus
);
    localparam int BLK_W = RATE_W * 64;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [4:0]       wcnt_q, wcnt_d;
    logic [BLK_W-1:0] blk_buf_q, blk_buf_d;
    logic             pad_pend_q, pad_pend_d;
    logic             first_f_q, first_f_d;
    logic             blk_last_q, blk_last_d;

    logic [3:0]  n_eff;
    logic [63:0] word_masked;
    logic [7:0]  byte_pos;
    logic        emit;

    // Tail bytes beyond in_nbytes are zeroed so padding XORs onto clean bytes.
    always_comb begin
        n_eff       = (bus.in_nbytes > 4'd8) ? 4'd8 : bus.in_nbytes;
        word_masked = bus.in_data;
        if (bus.in_last) begin
            for (int j = 0; j < 8; j++) begin
                if (j >= int'(n_eff)) begin
                    word_masked[8*j +: 8] = 8'h00;
                end
            end
        end
    end

    // Message byte position right after the final data byte (0..136).
    assign byte_pos = {wcnt_q, 3'b000} + {4'b0000, n_eff};

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        blk_buf_d  = blk_buf_q;
        pad_pend_d = pad_pend_q;
        first_f_d  = first_f_q;
        blk_last_d = blk_last_q;

        if (state_q == ST_FILL) begin
            if (bus.in_valid) begin
                blk_buf_d[{wcnt_q, 6'b000000} +: 64] = word_masked;
                if (bus.in_last) begin
                    state_d = ST_EMIT;
                    if (byte_pos < 8'd136) begin
                        blk_buf_d[{byte_pos, 3'b000} +: 8] =
                            blk_buf_d[{byte_pos, 3'b000} +: 8] ^ 8'h06;
                        blk_buf_d[BLK_W-1 -: 8] = blk_buf_d[BLK_W-1 -: 8] ^ 8'h80;
                        blk_last_d = 1'b1;
                    end else begin
                        // Message exactly filled the rate: padding needs its own block.
                        blk_last_d = 1'b0;
                        pad_pend_d = 1'b1;
                    end
                end else if (wcnt_q == 5'(RATE_W - 1)) begin
                    state_d    = ST_EMIT;
                    blk_last_d = 1'b0;
                end else begin
                    wcnt_d = wcnt_q + 5'd1;
                end
            end
        end else begin
            if (bus.blk_ready) begin
                blk_buf_d = '0;
                wcnt_d    = '0;
                if (pad_pend_q) begin
                    blk_buf_d[7:0]          = 8'h06;
                    blk_buf_d[BLK_W-1 -: 8] = 8'h80;
                    blk_last_d = 1'b1;
                    pad_pend_d = 1'b0;
                    first_f_d  = 1'b0;
                end else begin
                    first_f_d = blk_last_q;
                    state_d   = ST_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            wcnt_q     <= '0;
            blk_buf_q  <= '0;
            pad_pend_q <= 1'b0;
            first_f_q  <= 1'b1;
            blk_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            blk_buf_q  <= blk_buf_d;
            pad_pend_q <= pad_pend_d;
            first_f_q  <= first_f_d;
            blk_last_q <= blk_last_d;
        end
    end

    assign emit          = (state_q == ST_EMIT) && !rst;
    assign bus.in_ready  = (state_q == ST_FILL) && !rst;
    assign bus.blk_valid = emit;
    assign bus.blk_data  = blk_buf_q;
    assign bus.blk_first = emit && first_f_q;
    assign bus.blk_last  = emit && blk_last_q;
endmodule

// File: tb/tb_sha3_256_padder.sv
module tb_sha3_256_padder;
    logic clk;
    logic rst;
    sha3_256_padder_if ifc ();

    sha3_256_padder dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        last;
        logic [3:0]  n;
        logic        done;
    } word_t;

    typedef struct {
        logic [1087:0] d;
        logic          first;
        logic          last;
    } blk_t;

    word_t        wq[$];
    blk_t         eq[$];
    byte unsigned msg[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: append 0x06, zero-fill to a multiple of 136 bytes, XOR 0x80 into the final byte.
    task automatic add_msg(input bit garbage);
        int len, nw, plen, nblk;
        byte unsigned pb[];
        len = msg.size();
        nw  = (len == 0) ? 1 : (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            word_t x;
            x.d = garbage ? {$urandom, $urandom} : 64'h0;
            for (int b = 0; b < 8; b++)
                if (8*w + b < len) x.d[8*b +: 8] = msg[8*w + b];
            x.last = (w == nw - 1);
            x.n    = x.last ? 4'(len - 8*w) : 4'd8;
            x.done = x.last || (w % 17 == 16);
            wq.push_back(x);
        end
        plen = (len / 136 + 1) * 136;
        nblk = plen / 136;
        pb = new[plen];
        for (int i = 0; i < plen; i++) pb[i] = (i < len) ? msg[i] : 8'h00;
        pb[len]      = pb[len] ^ 8'h06;
        pb[plen - 1] = pb[plen - 1] ^ 8'h80;
        for (int k = 0; k < nblk; k++) begin
            blk_t e;
            for (int i = 0; i < 136; i++) e.d[8*i +: 8] = pb[136*k + i];
            e.first = (k == 0);
            e.last  = (k == nblk - 1);
            eq.push_back(e);
        end
    endtask

    task automatic run(input int hold);
        int cyc = 0;
        int held = 0;
        bit done_prev = 0;
        bit stall_prev = 0;
        logic [1087:0] prev_data = '0;
        while ((wq.size() > 0 || eq.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (done_prev) chk("valid_latency", ifc.blk_valid, 1);
            if (stall_prev) begin
                chk("hold_valid", ifc.blk_valid, 1);
                chk("hold_stable", ifc.blk_data === prev_data, 1);
            end
            chk("ready_xor_valid", ifc.in_ready ^ ifc.blk_valid, 1);
            if (wq.size() > 0) begin
                ifc.in_valid  = 1'b1;
                ifc.in_data   = wq[0].d;
                ifc.in_last   = wq[0].last;
                ifc.in_nbytes = wq[0].n;
            end else begin
                ifc.in_valid  = 1'b0;
                ifc.in_data   = {$urandom, $urandom};
                ifc.in_last   = 1'($urandom);
                ifc.in_nbytes = 4'($urandom);
            end
            if (ifc.blk_valid && held < hold) begin
                ifc.blk_ready = 1'b0;
                held++;
            end else begin
                ifc.blk_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            done_prev  = 0;
            stall_prev = ifc.blk_valid && !ifc.blk_ready;
            prev_data  = ifc.blk_data;
            if (ifc.blk_valid && ifc.blk_ready) begin
                if (eq.size() == 0) begin
                    chk("extra_block", 1, 0);
                end else begin
                    for (int k = 0; k < 17; k++)
                        chk($sformatf("blk_lane%0d", k), ifc.blk_data[64*k +: 64], eq[0].d[64*k +: 64]);
                    chk("blk_first", ifc.blk_first, eq[0].first);
                    chk("blk_last", ifc.blk_last, eq[0].last);
                    void'(eq.pop_front());
                end
                held = 0;
            end
            if (ifc.in_valid && ifc.in_ready) begin
                done_prev = wq[0].done;
                void'(wq.pop_front());
            end
        end
        chk("timeout", cyc < 5000, 1);
        wq.delete();
        eq.delete();
        @(negedge clk);
        ifc.in_valid  = 1'b0;
        ifc.blk_ready = 1'b0;
    endtask

    task automatic push_words(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            ifc.in_valid  = 1'b1;
            ifc.in_data   = {$urandom, $urandom};
            ifc.in_last   = 1'b0;
            ifc.in_nbytes = 4'd8;
            ifc.blk_ready = 1'b0;
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic rand_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.in_nbytes = '0;
        ifc.blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 0);
        chk("rst_blk_valid", ifc.blk_valid, 0);
        chk("rst_blk_first", ifc.blk_first, 0);
        chk("rst_blk_last", ifc.blk_last, 0);
        chk("rst_blk_data", ifc.blk_data === '0, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", ifc.in_ready, 1);

        // empty message
        msg.delete();
        add_msg(1);
        run(0);

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        add_msg(0);
        run(0);

        // 135 bytes: suffix and final bit share byte 135
        rand_msg(135);
        add_msg(1);
        run(0);

        // 136 bytes: data block then a padding-only block
        rand_msg(136);
        add_msg(1);
        run(0);

        // backpressure with the next message already waiting
        rand_msg(20);
        add_msg(1);
        rand_msg(9);
        add_msg(1);
        run(5);

        // reset mid-fill, then "abc" must come out clean
        push_words(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        add_msg(0);
        run(0);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_valid", ifc.blk_valid, 0);
        end

        // reset mid-emit
        push_words(17);
        chk("full_block_valid", ifc.blk_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_emit_valid", ifc.blk_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_emit_in_ready", ifc.in_ready, 1);

        // randomized messages back to back
        for (int r = 0; r < 6; r++) begin
            rand_msg($urandom_range(0, 300));
            add_msg(1);
        end
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
